// File: rtl/gtwizard_pkg.sv
// Shared state encoding and default timing for the GTX RX start-up sequencer.
// The FSM_STATE_OUT debug port exposes these encodings directly.
package gtwizard_pkg;

  typedef enum logic [3:0] {
    ST_INIT              = 4'd0,
    ST_ASSERT_CPLLRESET  = 4'd1,
    ST_WAIT_CPLLLOCK     = 4'd2,
    ST_RELEASE_GTRXRESET = 4'd3,
    ST_WAIT_RESETDONE    = 4'd4,
    ST_WAIT_DATA_VALID   = 4'd5,
    ST_DONE              = 4'd6,
    ST_ASSERT_GTRXRESET  = 4'd7,
    ST_RETRY             = 4'd8
  } rx_state_t;

  localparam int unsigned DEF_STARTUP_DELAY_CYCLES = 500;
  localparam int unsigned DEF_CPLL_RESET_CYCLES    = 16;
  localparam int unsigned DEF_CDR_LOCK_CYCLES      = 5000;
  localparam int unsigned DEF_DATA_VALID_CYCLES    = 64;
  localparam int unsigned DEF_WAIT_TIMEOUT_CYCLES  = 100000;
  localparam int unsigned DEF_RETRY_W              = 4;

  localparam int unsigned SYNC_STAGES           = 3;
  localparam int unsigned DATA_LOSS_CYCLES      = 8;
  localparam int unsigned GTRXRESET_HOLD_CYCLES = 4;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/gtwizard_sync_block.sv
// Multi-flop synchroniser bringing a GT status bit into the system clock domain.
// Output lags the input by STAGES cycles and clears on soft reset.
module gtwizard_sync_block #(
  parameter int unsigned STAGES = 3
) (
  input  logic clk,
  input  logic srst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_reg;

  always_ff @(posedge clk) begin
    if (srst) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[STAGES-2:0], d};
    end
  end

  assign q = sync_reg[STAGES-1];

endmodule

// File: rtl/gtwizard_rx_startup_fsm.sv
// GTX RX bring-up sequencer for the SATA PHY: CPLL reset, GTRXRESET release,
// CDR wait, RXUSERRDY, reset-done and data-valid qualification, loss monitoring.
module gtwizard_rx_startup_fsm
  import gtwizard_pkg::*;
#(
  parameter int unsigned STARTUP_DELAY_CYCLES = DEF_STARTUP_DELAY_CYCLES,
  parameter int unsigned CPLL_RESET_CYCLES    = DEF_CPLL_RESET_CYCLES,
  parameter int unsigned CDR_LOCK_CYCLES      = DEF_CDR_LOCK_CYCLES,
  parameter int unsigned DATA_VALID_CYCLES    = DEF_DATA_VALID_CYCLES,
  parameter int unsigned WAIT_TIMEOUT_CYCLES  = DEF_WAIT_TIMEOUT_CYCLES,
  parameter int unsigned RETRY_W              = DEF_RETRY_W
) (
  input  logic               SYSCLK_IN,
  input  logic               SOFT_RESET_IN,
  input  logic               CPLLLOCK_IN,
  input  logic               RXRESETDONE_IN,
  input  logic               DATA_VALID_IN,
  output logic               CPLLRESET_OUT,
  output logic               GTRXRESET_OUT,
  output logic               RXUSERRDY_OUT,
  output logic               RX_FSM_RESET_DONE_OUT,
  output logic [RETRY_W-1:0] RETRY_COUNTER_OUT,
  output logic [3:0]         FSM_STATE_OUT
);

  localparam int unsigned MAX_CYCLES = max_u(max_u(max_u(STARTUP_DELAY_CYCLES, CPLL_RESET_CYCLES),
                                                   max_u(CDR_LOCK_CYCLES, DATA_VALID_CYCLES)),
                                             WAIT_TIMEOUT_CYCLES);
  localparam int unsigned TIMER_W = (MAX_CYCLES > 2) ? $clog2(MAX_CYCLES) : 2;
  localparam int unsigned RUN_W   = $clog2(DATA_VALID_CYCLES + 1);
  localparam int unsigned LOSS_W  = $clog2(DATA_LOSS_CYCLES + 1);

  // Terminal counts are one less than the cycle counts since timers start at zero.
  localparam logic [TIMER_W-1:0] TIMER_MAX = '1;
  localparam logic [TIMER_W-1:0] T_STARTUP = TIMER_W'(STARTUP_DELAY_CYCLES - 1);
  localparam logic [TIMER_W-1:0] T_CPLL    = TIMER_W'(CPLL_RESET_CYCLES - 1);
  localparam logic [TIMER_W-1:0] T_CDR     = TIMER_W'(CDR_LOCK_CYCLES - 1);
  localparam logic [TIMER_W-1:0] T_TIMEOUT = TIMER_W'(WAIT_TIMEOUT_CYCLES - 1);
  localparam logic [TIMER_W-1:0] T_HOLD    = TIMER_W'(GTRXRESET_HOLD_CYCLES - 1);
  localparam logic [RUN_W-1:0]   RUN_LAST  = RUN_W'(DATA_VALID_CYCLES - 1);
  localparam logic [LOSS_W-1:0]  LOSS_LAST = LOSS_W'(DATA_LOSS_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX = '1;

  logic [2:0] async_in;
  logic [2:0] sync_out;
  logic       cplllock_s;
  logic       rxresetdone_s;
  logic       data_valid_s;

  rx_state_t          state_reg, state_next;
  logic [TIMER_W-1:0] timer_reg, timer_next;
  logic [RUN_W-1:0]   run_reg, run_next;
  logic [LOSS_W-1:0]  loss_reg, loss_next;
  logic [RETRY_W-1:0] retry_reg, retry_next;
  logic               cpllreset_reg, cpllreset_next;
  logic               gtrxreset_reg, gtrxreset_next;
  logic               rxuserrdy_reg, rxuserrdy_next;
  logic               done_reg, done_next;

  assign async_in = {DATA_VALID_IN, RXRESETDONE_IN, CPLLLOCK_IN};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_sync
      gtwizard_sync_block #(
        .STAGES (SYNC_STAGES)
      ) u_sync (
        .clk  (SYSCLK_IN),
        .srst (SOFT_RESET_IN),
        .d    (async_in[gi]),
        .q    (sync_out[gi])
      );
    end
  endgenerate

  assign cplllock_s    = sync_out[0];
  assign rxresetdone_s = sync_out[1];
  assign data_valid_s  = sync_out[2];

  always_ff @(posedge SYSCLK_IN) begin
    if (SOFT_RESET_IN) begin
      state_reg     <= ST_INIT;
      timer_reg     <= '0;
      run_reg       <= '0;
      loss_reg      <= '0;
      retry_reg     <= '0;
      cpllreset_reg <= 1'b0;
      gtrxreset_reg <= 1'b1;
      rxuserrdy_reg <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      timer_reg     <= timer_next;
      run_reg       <= run_next;
      loss_reg      <= loss_next;
      retry_reg     <= retry_next;
      cpllreset_reg <= cpllreset_next;
      gtrxreset_reg <= gtrxreset_next;
      rxuserrdy_reg <= rxuserrdy_next;
      done_reg      <= done_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    timer_next = timer_reg;
    run_next   = run_reg;
    loss_next  = loss_reg;

    unique case (state_reg)
      ST_INIT: begin
        if (timer_reg == T_STARTUP) state_next = ST_ASSERT_CPLLRESET;
      end
      ST_ASSERT_CPLLRESET: begin
        if (timer_reg == T_CPLL) state_next = ST_WAIT_CPLLLOCK;
      end
      ST_WAIT_CPLLLOCK: begin
        if (cplllock_s)                   state_next = ST_RELEASE_GTRXRESET;
        else if (timer_reg == T_TIMEOUT)  state_next = ST_RETRY;
      end
      ST_RELEASE_GTRXRESET: begin
        if (timer_reg == T_CDR) state_next = ST_WAIT_RESETDONE;
      end
      ST_WAIT_RESETDONE: begin
        if (rxresetdone_s)                state_next = ST_WAIT_DATA_VALID;
        else if (timer_reg == T_TIMEOUT)  state_next = ST_RETRY;
      end
      ST_WAIT_DATA_VALID: begin
        run_next = data_valid_s ? run_reg + 1'b1 : '0;
        if (data_valid_s && run_reg == RUN_LAST) state_next = ST_DONE;
        else if (timer_reg == T_TIMEOUT)         state_next = ST_RETRY;
      end
      ST_DONE: begin
        // Lock loss wins over data loss: it needs the full CPLL re-sequence.
        loss_next = data_valid_s ? '0 : loss_reg + 1'b1;
        if (!cplllock_s)                              state_next = ST_RETRY;
        else if (!data_valid_s && loss_reg == LOSS_LAST) state_next = ST_ASSERT_GTRXRESET;
      end
      ST_ASSERT_GTRXRESET: begin
        if (timer_reg == T_HOLD) state_next = ST_RELEASE_GTRXRESET;
      end
      ST_RETRY: begin
        state_next = ST_ASSERT_CPLLRESET;
      end
      default: begin
        state_next = ST_INIT;
      end
    endcase

    if (state_next != state_reg) begin
      timer_next = '0;
      run_next   = '0;
      loss_next  = '0;
    end else if (timer_reg != TIMER_MAX) begin
      timer_next = timer_reg + 1'b1;
    end

    // Outputs follow the current state and are registered, so they trail it by one cycle.
    cpllreset_next = (state_reg == ST_ASSERT_CPLLRESET);
    gtrxreset_next = state_reg inside {ST_INIT, ST_ASSERT_CPLLRESET, ST_WAIT_CPLLLOCK,
                                       ST_ASSERT_GTRXRESET, ST_RETRY};
    rxuserrdy_next = state_reg inside {ST_WAIT_RESETDONE, ST_WAIT_DATA_VALID, ST_DONE};
    done_next      = (state_reg == ST_DONE);
    retry_next     = (state_reg == ST_RETRY && retry_reg != RETRY_MAX) ? retry_reg + 1'b1
                                                                       : retry_reg;
  end

  assign CPLLRESET_OUT         = cpllreset_reg;
  assign GTRXRESET_OUT         = gtrxreset_reg;
  assign RXUSERRDY_OUT         = rxuserrdy_reg;
  assign RX_FSM_RESET_DONE_OUT = done_reg;
  assign RETRY_COUNTER_OUT     = retry_reg;
  assign FSM_STATE_OUT         = state_reg;

endmodule

// File: tb/tb_gtwizard_rx_startup_fsm.sv
// Self-checking bench: per-scenario input waveforms, a phase/duration reference model
// predicting every output cycle, plus event-level checks on the observed waveform.
module tb_gtwizard_rx_startup_fsm;

  localparam int STARTUP = 10;
  localparam int CPLLR   = 4;
  localparam int CDR     = 20;
  localparam int DV      = 8;
  localparam int TO      = 200;
  localparam int RW      = 4;
  localparam int LOSS    = 8;
  localparam int HOLD    = 4;
  localparam int RMAX    = (1 << RW) - 1;
  localparam int MAXN    = 5000;
  localparam int DLY     = 3;

  localparam int SIG_LOCK = 0;
  localparam int SIG_RD   = 1;
  localparam int SIG_DV   = 2;

  // Expected output patterns {cpllreset, gtrxreset, rxuserrdy, done}
  localparam logic [3:0] O_HOLD = 4'b0100;
  localparam logic [3:0] O_CPLL = 4'b1100;
  localparam logic [3:0] O_CDR  = 4'b0000;
  localparam logic [3:0] O_RDY  = 4'b0010;
  localparam logic [3:0] O_UP   = 4'b0011;

  localparam int PH_CPLL  = 0;
  localparam int PH_LOCK  = 1;
  localparam int PH_CDR   = 2;
  localparam int PH_RDONE = 3;
  localparam int PH_DV    = 4;
  localparam int PH_UP    = 5;
  localparam int PH_RXRST = 6;
  localparam int PH_RETRY = 7;

  logic          clk  = 1'b0;
  logic          srst = 1'b1;
  logic          lock = 1'b0;
  logic          rd   = 1'b0;
  logic          dv   = 1'b0;
  logic          cpllreset, gtrxreset, rxuserrdy, done;
  logic [RW-1:0] retry_cnt;
  logic [3:0]    fsm_state;

  gtwizard_rx_startup_fsm #(
    .STARTUP_DELAY_CYCLES (STARTUP),
    .CPLL_RESET_CYCLES    (CPLLR),
    .CDR_LOCK_CYCLES      (CDR),
    .DATA_VALID_CYCLES    (DV),
    .WAIT_TIMEOUT_CYCLES  (TO),
    .RETRY_W              (RW)
  ) dut (
    .SYSCLK_IN             (clk),
    .SOFT_RESET_IN         (srst),
    .CPLLLOCK_IN           (lock),
    .RXRESETDONE_IN        (rd),
    .DATA_VALID_IN         (dv),
    .CPLLRESET_OUT         (cpllreset),
    .GTRXRESET_OUT         (gtrxreset),
    .RXUSERRDY_OUT         (rxuserrdy),
    .RX_FSM_RESET_DONE_OUT (done),
    .RETRY_COUNTER_OUT     (retry_cnt),
    .FSM_STATE_OUT         (fsm_state)
  );

  always #5 clk = ~clk;

  initial begin
    #50000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  int n_cmp = 0;
  int n_mis = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  bit         in_lock [MAXN];
  bit         in_rd   [MAXN];
  bit         in_dv   [MAXN];
  logic [3:0] e_out   [MAXN];
  int         e_retry [MAXN];
  logic [3:0] o_out   [MAXN];
  int         o_retry [MAXN];

  int mc, mretry, m_len, m_rd_start;

  task automatic clear_stim();
    for (int c = 0; c < MAXN; c++) begin
      in_lock[c] = 1'b0;
      in_rd[c]   = 1'b0;
      in_dv[c]   = 1'b0;
    end
  endtask

  task automatic stim(input int which, input int from, input int to, input bit v);
    for (int c = from; c < to && c < MAXN; c++) begin
      if (c >= 0) begin
        case (which)
          SIG_LOCK: in_lock[c] = v;
          SIG_RD:   in_rd[c]   = v;
          default:  in_dv[c]   = v;
        endcase
      end
    end
  endtask

  // The sequencer acts on each input DLY cycles after it is applied.
  function automatic bit lk(input int e);
    return (e >= DLY && e - DLY < MAXN) ? in_lock[e - DLY] : 1'b0;
  endfunction
  function automatic bit rdn(input int e);
    return (e >= DLY && e - DLY < MAXN) ? in_rd[e - DLY] : 1'b0;
  endfunction
  function automatic bit dvn(input int e);
    return (e >= DLY && e - DLY < MAXN) ? in_dv[e - DLY] : 1'b0;
  endfunction

  task automatic put(input int n, input logic [3:0] o);
    for (int i = 0; i < n; i++) begin
      if (mc < m_len) begin
        e_out[mc]   = o;
        e_retry[mc] = mretry;
      end
      mc++;
    end
  endtask

  // Walks the bring-up phases, computing each phase's duration from the input waveform.
  task automatic model_build(input int len);
    int ph;
    int k;
    int run;
    bit hit;
    m_len = len; mc = 0; mretry = 0; m_rd_start = -1;
    put(STARTUP, O_HOLD);
    ph = PH_CPLL;
    while (mc < len) begin
      case (ph)
        PH_CPLL: begin
          put(CPLLR, O_CPLL);
          ph = PH_LOCK;
        end
        PH_LOCK: begin
          hit = 1'b0;
          for (k = 0; k < TO; k++) if (lk(mc + k)) begin hit = 1'b1; break; end
          if (hit) begin put(k + 1, O_HOLD); ph = PH_CDR; end
          else begin put(TO, O_HOLD); ph = PH_RETRY; end
        end
        PH_CDR: begin
          put(CDR, O_CDR);
          ph = PH_RDONE;
        end
        PH_RDONE: begin
          if (m_rd_start < 0) m_rd_start = mc;
          hit = 1'b0;
          for (k = 0; k < TO; k++) if (rdn(mc + k)) begin hit = 1'b1; break; end
          if (hit) begin put(k + 1, O_RDY); ph = PH_DV; end
          else begin put(TO, O_RDY); ph = PH_RETRY; end
        end
        PH_DV: begin
          hit = 1'b0; run = 0;
          for (k = 0; k < TO; k++) begin
            run = dvn(mc + k) ? run + 1 : 0;
            if (run == DV) begin hit = 1'b1; break; end
          end
          if (hit) begin put(k + 1, O_RDY); ph = PH_UP; end
          else begin put(TO, O_RDY); ph = PH_RETRY; end
        end
        PH_UP: begin
          run = 0; ph = PH_UP;
          for (k = 0; mc + k < len; k++) begin
            if (!lk(mc + k)) begin ph = PH_RETRY; break; end
            if (!dvn(mc + k)) begin
              run++;
              if (run == LOSS) begin ph = PH_RXRST; break; end
            end else begin
              run = 0;
            end
          end
          put(k + 1, O_UP);
        end
        PH_RXRST: begin
          put(HOLD, O_HOLD);
          ph = PH_CDR;
        end
        PH_RETRY: begin
          if (mretry < RMAX) mretry++;
          put(1, O_HOLD);
          ph = PH_CPLL;
        end
        default: mc = len;
      endcase
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    srst = 1'b1; lock = 1'b0; rd = 1'b0; dv = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_gtrxreset", 32'(gtrxreset), 32'd1);
    chk("rst_state", 32'(fsm_state), 32'd0);
    chk("rst_others", 32'({cpllreset, rxuserrdy, done, retry_cnt}), 32'd0);
    @(negedge clk);
    srst = 1'b0;
  endtask

  task automatic run_scn(input string name, input int len, input int rst_at);
    int mis0;
    int last;
    mis0 = n_mis;
    last = len - 1;
    model_build(len);
    apply_reset();
    for (int c = 0; c < len; c++) begin
      if (c == rst_at) begin
        srst = 1'b1;
        @(posedge clk);
        #1;
        chk("srst_gtrxreset", 32'(gtrxreset), 32'd1);
        chk("srst_rxuserrdy", 32'(rxuserrdy), 32'd0);
        chk("srst_counter", 32'(retry_cnt), 32'd0);
        chk("srst_state", 32'(fsm_state), 32'd0);
        chk("srst_cpll_done", 32'({cpllreset, done}), 32'd0);
        @(negedge clk);
        srst = 1'b0;
        last = c - 1;
        break;
      end
      lock = in_lock[c]; rd = in_rd[c]; dv = in_dv[c];
      @(posedge clk);
      #1;
      o_out[c]   = {cpllreset, gtrxreset, rxuserrdy, done};
      o_retry[c] = int'(retry_cnt);
      chk($sformatf("%s_cyc%0d", name, c),
          32'({o_out[c], retry_cnt}), 32'({e_out[c], RW'(e_retry[c])}));
      @(negedge clk);
    end
    $display("scenario %-10s cycles=%0d retries=%0d done=%0b new_mismatches=%0d",
             name, last + 1, o_retry[last], o_out[last][0], n_mis - mis0);
  endtask

  function automatic int count_hi(input int bitn, input int from, input int to);
    int n = 0;
    for (int c = from; c < to; c++) if (o_out[c][bitn]) n++;
    return n;
  endfunction

  function automatic int first_eq(input int bitn, input bit v, input int len);
    for (int c = 0; c < len; c++) if (o_out[c][bitn] == v) return c;
    return -1;
  endfunction

  initial begin
    int d;
    int p;

    // Nominal bring-up
    clear_stim();
    stim(SIG_LOCK, 30, MAXN, 1); stim(SIG_RD, 70, MAXN, 1); stim(SIG_DV, 90, MAXN, 1);
    run_scn("nominal", 250, -1);
    chk("nom_cpll_width", 32'(count_hi(3, 0, 250)), 32'd4);
    chk("nom_cdr_wait", 32'(first_eq(1, 1'b1, 250) - first_eq(2, 1'b0, 250)), 32'(CDR));
    chk("nom_done", 32'(o_out[249][0]), 32'd1);
    chk("nom_retry", 32'(o_retry[249]), 32'd0);

    // CPLL never locks: two timeouts, three CPLL reset pulses
    clear_stim();
    run_scn("nolock", 430, -1);
    chk("nolock_retry_mid", 32'(o_retry[300]), 32'd1);
    chk("nolock_retry_end", 32'(o_retry[429]), 32'd2);
    chk("nolock_cpll_cycles", 32'(count_hi(3, 0, 430)), 32'd12);

    // Data valid toggling with period 6, then steady
    clear_stim();
    stim(SIG_LOCK, 30, MAXN, 1); stim(SIG_RD, 70, MAXN, 1);
    for (int c = 90; c < 420; c++) in_dv[c] = ((c - 90) % 6) < 3;
    stim(SIG_DV, 420, MAXN, 1);
    run_scn("dvtoggle", 600, -1);
    chk("dvtog_no_early_done", 32'(count_hi(0, 0, 400)), 32'd0);
    chk("dvtog_retry", 32'(o_retry[599]), 32'd1);
    chk("dvtog_done", 32'(o_out[599][0]), 32'd1);

    // Data loss of 7 cycles (tolerated) and 8 cycles (GTRXRESET re-pulse)
    clear_stim();
    stim(SIG_LOCK, 30, MAXN, 1); stim(SIG_RD, 70, MAXN, 1); stim(SIG_DV, 90, MAXN, 1);
    stim(SIG_DV, 250, 257, 0); stim(SIG_DV, 350, 358, 0);
    run_scn("dvloss", 600, -1);
    chk("dvloss7_done_held", 32'(count_hi(0, 240, 350)), 32'd110);
    chk("dvloss8_gtrx_cycles", 32'(count_hi(2, 300, 600)), 32'(HOLD));
    chk("dvloss8_retry", 32'(o_retry[599]), 32'd0);
    chk("dvloss8_done", 32'(o_out[599][0]), 32'd1);

    // Lock and data lost together: retry path wins
    clear_stim();
    d = $urandom_range(40, 5);
    stim(SIG_LOCK, 30, MAXN, 1); stim(SIG_RD, 70, MAXN, 1); stim(SIG_DV, 90, MAXN, 1);
    stim(SIG_LOCK, 250, 250 + d, 0); stim(SIG_DV, 250, 260 + d, 0);
    run_scn("lockloss", 700, -1);
    chk("lockloss_retry", 32'(o_retry[699]), 32'd1);
    chk("lockloss_cpll_cycles", 32'(count_hi(3, 0, 700)), 32'd8);
    chk("lockloss_done", 32'(o_out[699][0]), 32'd1);

    // Soft reset while waiting for RX reset done, after one retry
    clear_stim();
    stim(SIG_LOCK, 300, MAXN, 1); stim(SIG_RD, 700, MAXN, 1); stim(SIG_DV, 720, MAXN, 1);
    model_build(800);
    run_scn("softrst", 800, m_rd_start + $urandom_range(6, 1));

    // Twenty timeouts: counter saturates
    clear_stim();
    run_scn("saturate", STARTUP + 20 * (CPLLR + TO + 1) + 20, -1);
    chk("sat_retry", 32'(o_retry[STARTUP + 20 * (CPLLR + TO + 1) + 19]), 32'(RMAX));

    // Randomized waveforms
    for (int it = 0; it < 6; it++) begin
      int tl;
      int tr;
      int td;
      clear_stim();
      tl = $urandom_range(450, 0);
      tr = tl + $urandom_range(300, 0);
      td = tr + $urandom_range(250, 0);
      stim(SIG_LOCK, tl, MAXN, 1); stim(SIG_RD, tr, MAXN, 1); stim(SIG_DV, td, MAXN, 1);
      repeat (25) begin
        p = $urandom_range(1400, 0);
        stim(SIG_DV, p, p + $urandom_range(10, 1), 0);
      end
      if ($urandom_range(1, 0) == 1) begin
        p = $urandom_range(1400, 0);
        stim(SIG_LOCK, p, p + $urandom_range(60, 1), 0);
      end
      run_scn($sformatf("rand%0d", it), 1500, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
